// File: rtl/noc_output_arbiter_pkg.sv
// rtl/noc_output_arbiter_pkg.sv - link flit format and arbiter types shared by the output port logic
package interact;

    localparam int LINK_WIDTH = 16;
    localparam int NUM_PORTS  = 4;

    localparam int VLD_BIT = LINK_WIDTH - 1;
    localparam int SOP_BIT = LINK_WIDTH - 2;
    localparam int EOP_BIT = LINK_WIDTH - 3;

    typedef struct packed {
        logic [LINK_WIDTH-1:0] data;
    } channel_forward;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/noc_output_arbiter_rr_picker.sv
// rtl/noc_output_arbiter_rr_picker.sv - combinational 4-way round-robin picker, first candidate at or after ptr
module rr_picker (
    input  logic [3:0] cand,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] pos;

    always_comb begin
        grant = '0;
        idx   = ptr;
        any   = 1'b0;
        pos   = ptr;
        for (int k = 0; k < 4; k++) begin
            pos = ptr + 2'(k);
            if (!any && cand[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - round-robin packet-locking arbiter for one router output link with idle watchdog
module noc_output_arbiter
    import interact::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  channel_forward       inLine [NUM_PORTS],
    output channel_forward       outLine,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 busy,
    output logic [1:0]           owner,
    output logic                 timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t      state_q, state_n;
    logic [1:0]      ptr_q, ptr_n;
    logic [1:0]      owner_q, owner_n;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_n;
    logic            expire;

    logic [NUM_PORTS-1:0]  present, sop, eop, cand;
    logic [NUM_PORTS-1:0]  grant_c;
    logic [3:0]            pick_grant;
    logic [1:0]            pick_idx;
    logic                  pick_any;
    logic [LINK_WIDTH-1:0] gdata;

    always_comb begin
        present = '0;
        sop     = '0;
        eop     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sop[i]     = inLine[i].data[SOP_BIT];
            eop[i]     = inLine[i].data[EOP_BIT];
            present[i] = inLine[i].data[VLD_BIT] | sop[i] | eop[i];
        end
    end

    assign cand = req & present & sop;

    rr_picker u_picker (
        .cand  (cand),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_n    = state_q;
        ptr_n      = ptr_q;
        owner_n    = owner_q;
        idle_cnt_n = idle_cnt_q;
        grant_c    = '0;
        expire     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                grant_c = pick_grant;
                if (pick_any) begin
                    if (eop[pick_idx]) begin
                        ptr_n = pick_idx + 2'd1;
                    end else begin
                        state_n    = ARB_BUSY;
                        owner_n    = pick_idx;
                        idle_cnt_n = '0;
                    end
                end
            end
            ARB_BUSY: begin
                if (req[owner_q] && present[owner_q]) begin
                    grant_c[owner_q] = 1'b1;
                    idle_cnt_n       = '0;
                    if (eop[owner_q]) begin
                        state_n = ARB_IDLE;
                        ptr_n   = owner_q + 2'd1;
                    end
                end else if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
                    // Owner went silent mid-packet: drop the lock, nothing is forwarded for it.
                    state_n = ARB_IDLE;
                    ptr_n   = owner_q + 2'd1;
                    expire  = 1'b1;
                end else begin
                    idle_cnt_n = idle_cnt_q + CW'(1);
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    assign grant = reset ? '0 : grant_c;

    always_comb begin
        gdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) gdata = gdata | inLine[i].data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            idle_cnt_q   <= '0;
            outLine.data <= '0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_n;
            ptr_q        <= ptr_n;
            owner_q      <= owner_n;
            idle_cnt_q   <= idle_cnt_n;
            outLine.data <= gdata;
            timeout      <= expire;
        end
    end

    assign busy  = (state_q == ARB_BUSY);
    assign owner = owner_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - directed self-checking bench for noc_output_arbiter
module tb_noc_output_arbiter;
    import interact::*;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     req;
    channel_forward in_line [4];
    channel_forward out_line;
    logic [3:0]     grant;
    logic           busy;
    logic [1:0]     owner;
    logic           timeout;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    noc_output_arbiter #(.NUM_PORTS(4), .TIMEOUT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .inLine  (in_line),
        .outLine (out_line),
        .grant   (grant),
        .busy    (busy),
        .owner   (owner),
        .timeout (timeout)
    );

    function automatic logic [15:0] fsop(input logic [12:0] p);
        return 16'hC000 | {3'b000, p};
    endfunction
    function automatic logic [15:0] fbody(input logic [12:0] p);
        return 16'h8000 | {3'b000, p};
    endfunction
    function automatic logic [15:0] feop(input logic [12:0] p);
        return 16'hA000 | {3'b000, p};
    endfunction
    function automatic logic [15:0] fsingle(input logic [12:0] p);
        return 16'hE000 | {3'b000, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) in_line[i].data = '0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < 4; i++) in_line[i].data = fsop(13'(i));
        #1;
        chk("reset_grant_forced", 32'(grant), 32'h0);
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_out", 32'(out_line.data), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        chk("reset_grant", 32'(grant), 32'h0);

        // single 4-flit packet from input 2
        clear_inputs();
        reset = 1'b0;
        req = 4'b0100;
        in_line[2].data = fsop(13'h11);
        #2 chk("sp_grant0", 32'(grant), 32'h4);
        tick();
        chk("sp_out0", 32'(out_line.data), 32'(fsop(13'h11)));
        chk("sp_busy1", 32'(busy), 32'h1);
        chk("sp_owner", 32'(owner), 32'h2);
        in_line[2].data = fbody(13'h12);
        #2 chk("sp_grant1", 32'(grant), 32'h4);
        tick();
        chk("sp_out1", 32'(out_line.data), 32'(fbody(13'h12)));
        in_line[2].data = fbody(13'h13);
        #2 chk("sp_grant2", 32'(grant), 32'h4);
        tick();
        chk("sp_out2", 32'(out_line.data), 32'(fbody(13'h13)));
        in_line[2].data = feop(13'h14);
        #2 chk("sp_grant3", 32'(grant), 32'h4);
        chk("sp_busy_eop", 32'(busy), 32'h1);
        tick();
        chk("sp_out3", 32'(out_line.data), 32'(feop(13'h14)));
        chk("sp_busy_after", 32'(busy), 32'h0);
        chk("sp_ptr", 32'(dut.ptr_q), 32'h3);
        clear_inputs();

        // simultaneous SOPs after reset, round robin 0,1,2,3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) in_line[i].data = fsop(13'h20 + 13'(i));
        for (int i = 0; i < 4; i++) begin
            #2 chk("rr_sop_grant", 32'(grant), 32'(1 << i));
            tick();
            chk("rr_owner", 32'(owner), 32'(i));
            chk("rr_out_sop", 32'(out_line.data), 32'(fsop(13'h20 + 13'(i))));
            in_line[i].data = feop(13'h30 + 13'(i));
            #2 chk("rr_eop_grant", 32'(grant), 32'(1 << i));
            tick();
            chk("rr_out_eop", 32'(out_line.data), 32'(feop(13'h30 + 13'(i))));
            in_line[i].data = '0;
            req[i] = 1'b0;
        end
        clear_inputs();

        // lock hold: input 1 owns, input 3 waits with SOP (ptr is 0 here)
        req = 4'b0010;
        in_line[1].data = fsop(13'h41);
        #2 chk("lh_grant_sop", 32'(grant), 32'h2);
        tick();
        req = 4'b1010;
        in_line[1].data = fbody(13'h42);
        in_line[3].data = fsingle(13'h43);
        #2 chk("lh_grant_body", 32'(grant), 32'h2);
        tick();
        in_line[1].data = feop(13'h44);
        #2 chk("lh_grant_eop", 32'(grant), 32'h2);
        tick();
        req = 4'b1000;
        in_line[1].data = '0;
        // single-flit packet from input 3 right after the EOP
        #2 chk("lh_grant3", 32'(grant), 32'h8);
        tick();
        chk("sf_busy", 32'(busy), 32'h0);
        chk("sf_ptr", 32'(dut.ptr_q), 32'h0);
        chk("sf_out", 32'(out_line.data), 32'(fsingle(13'h43)));
        clear_inputs();

        // watchdog: input 0 sends SOP then nothing
        req = 4'b0001;
        in_line[0].data = fsop(13'h50);
        #2 chk("wd_grant", 32'(grant), 32'h1);
        tick();
        clear_inputs();
        chk("wd_out_sop", 32'(out_line.data), 32'(fsop(13'h50)));
        for (int k = 1; k <= 4; k++) begin
            chk("wd_timeout_low", 32'(timeout), 32'h0);
            chk("wd_busy_held", 32'(busy), 32'h1);
            tick();
        end
        chk("wd_timeout_pulse", 32'(timeout), 32'h1);
        chk("wd_busy_fall", 32'(busy), 32'h0);
        chk("wd_ptr", 32'(dut.ptr_q), 32'h1);
        chk("wd_out_zero", 32'(out_line.data), 32'h0);
        tick();
        chk("wd_timeout_once", 32'(timeout), 32'h0);

        // reset while input 2 owns the lock
        req = 4'b0100;
        in_line[2].data = fsop(13'h60);
        #2 chk("rm_grant_sop", 32'(grant), 32'h4);
        tick();
        chk("rm_busy", 32'(busy), 32'h1);
        in_line[2].data = fbody(13'h61);
        reset = 1'b1;
        #2 chk("rm_grant_forced", 32'(grant), 32'h0);
        tick();
        chk("rm_busy_after", 32'(busy), 32'h0);
        chk("rm_out_zero", 32'(out_line.data), 32'h0);
        chk("rm_grant_zero", 32'(grant), 32'h0);
        reset = 1'b0;
        req = 4'b0101;
        in_line[0].data = fsop(13'h70);
        in_line[2].data = fsop(13'h71);
        #2 chk("rm_first_grant", 32'(grant), 32'h1);
        tick();
        chk("rm_owner", 32'(owner), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

- Arbitrates one router output link among the four input ports.
- Each input port's header-processing unit decodes a destination and raises a per-output request. This block grants one packet at a time in round-robin order and locks the grant from the SOP flit through the EOP flit.
- It forwards the granted input's flits onto the output link through a register stage.
- A watchdog releases the lock if the owning input stops sending mid-packet.

## Interface
Parameters:
- `NUM_PORTS`, default 4: number of input ports; the design is fixed at 4.
- `TIMEOUT`, default 64: number of consecutive idle cycles inside a locked packet before the lock is force-released.

Ports:
- `clk`, input, 1: single clock. Everything samples on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req`, input, 4: `req[i]` means input `i`'s decoded select targets this output.
- `inLine`, input, `channel_forward` [4]: flits from the input ports.
- `outLine`, output, `channel_forward`: registered output flit.
- `grant`, input/output direction = output, 4: one-hot or zero, combinational. `grant[i]=1` means input `i`'s current flit is consumed this cycle.
- `busy`, output, 1: a packet lock is held.
- `owner`, output, 2: index of the locked input. Valid only while `busy`.
- `timeout`, output, 1: one-cycle pulse when the watchdog releases a lock.

## Operation
Flit fields, decoded from `data`:
- VLD = bit `LINK_WIDTH-1`, SOP = bit `LINK_WIDTH-2`, EOP = bit `LINK_WIDTH-3`.
- A flit is *present* when VLD|SOP|EOP.

States: IDLE and BUSY.

In IDLE:
- Candidates are inputs with `req[i]` set, a present flit, and SOP set.
- The round-robin picker chooses the first candidate starting at pointer `ptr`: ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- Winner `w` gets `grant[w]=1`.
- If the granted flit has EOP (single-flit packet), the state stays IDLE and `ptr` becomes w+1.
- Otherwise the state goes to BUSY with `owner`=w.

In BUSY:
- `grant[owner]=1` whenever `req[owner]` is set and owner's flit is present. All other grants are 0.
- A granted flit with EOP sends the state to IDLE and sets `ptr`=owner+1.
- An SOP flit from the owner while BUSY is treated as an ordinary flit and forwarded unchanged.

Forwarding:
- When any grant is set, `outLine.data` is loaded with `inLine[g].data` unmodified.
- Otherwise `outLine.data` is loaded with all zeros.

Requesters not granted must hold their flit. Upstream buffering is responsible for this; this block drops nothing it has not granted.

Watchdog:
- Counter `idle_cnt`, width `$clog2(TIMEOUT+1)`. It clears on entry to BUSY and on every granted flit, and increments on each BUSY cycle with no grant.
- When `idle_cnt` reaches TIMEOUT-1 on a non-granted BUSY cycle:
  - the state goes to IDLE;
  - `ptr` becomes owner+1;
  - `timeout` pulses on the next cycle;
  - no flit is synthesised on `outLine`.

## Timing
- Grant is combinational from `req`, `inLine`, the state and `ptr`, so it is decided in the same cycle the flit is presented.
- Output latency is 1 cycle: a flit granted in cycle N appears on `outLine` in cycle N+1.
- The EOP cycle releases the lock. A new SOP from any input can be granted in the next cycle, so there is no bubble between packets.
- Reset values:
  - state IDLE, `ptr`=0, `owner`=0, `idle_cnt`=0;
  - `outLine.data`=0, `busy`=0, `timeout`=0;
  - `grant` is forced to 0 while `reset` is high.
- Reset mid-packet abandons the lock immediately. The first cycle after reset is arbitrated from IDLE with `ptr`=0.
- When `req` is set without SOP in IDLE, there is no grant. An orphaned body flit is not forwarded.
- When several SOPs arrive at once, exactly one grant is given, by pointer order.
- Grant-with-EOP and the watchdog expiry cannot coincide, because a grant clears the counter.
- `busy` and `owner` are registered and reflect the state register.

## Structure
- Package `interact` holds:
  - existing: `LINK_WIDTH`, `channel_forward`;
  - to be added: `NUM_PORTS`, `VLD_BIT`/`SOP_BIT`/`EOP_BIT` index constants, and enum `arb_state_t` {ARB_IDLE, ARB_BUSY}.
- One sub-module: `rr_picker`. It is combinational, takes a 4-bit candidate vector and a 2-bit pointer, and outputs a one-hot grant plus an index. It is reusable by other output ports.

## Test plan
- **Single packet:** input 2 sends SOP, two body flits, then EOP, with `req`=0100. Required: `grant`=0100 for 4 cycles; `outLine` repeats the flits 1 cycle later; `busy` is 1 from cycle 2 through the EOP cycle; then `ptr`=3.
- **Simultaneous SOP, round robin:** `req`=1111 with all inputs presenting SOP after reset. Required: input 0 is granted; after its EOP, input 1 is granted, then 2, then 3. The other inputs receive `grant`=0 while holding their flit.
- **Lock hold:** while input 1 owns the lock, input 3 presents SOP. Required: `grant[3]`=0 until input 1's EOP; `grant[3]`=1 in the cycle after the EOP.
- **Single-flit packet:** input 3 sends a flit with SOP and EOP together. Required: state stays IDLE and `ptr`=0; input 0's SOP in the next cycle is granted.
- **Watchdog:** with `TIMEOUT`=4, input 0 sends SOP then goes silent. Required: `timeout` pulses exactly once, 5 cycles after the SOP grant; `busy` falls; `ptr`=1.
- **Reset mid-packet:** assert `reset` while input 2 owns the lock. Required: next cycle `busy`=0, `outLine.data`=0, `grant`=0; after release, input 0's SOP is granted first.
